// File: rtl/vdp_pkg.sv
// Shared VDP definitions: VRAM geometry, sprite attribute table locations,
// the read-server state encoding and the burst length type.
package vdp_pkg;

    localparam int VRAM_ADDR_W = 14;

    // Sprite attribute table layout in VRAM
    localparam logic [VRAM_ADDR_W-1:0] SAT_VPOS_BASE = 14'h3F00;
    localparam logic [VRAM_ADDR_W-1:0] SAT_HPOS_BASE = 14'h3F80;
    // VPOS value that terminates the sprite list
    localparam logic [7:0]             SAT_END       = 8'hD0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_TAIL  = 2'd2
    } srv_state_t;

    // Burst length minus one: 0 -> 1 byte, 3 -> 4 bytes
    typedef logic [1:0] burst_len_t;

endpackage

// File: rtl/vdp_vram_wr_buf.sv
// One-entry CPU write buffer in front of the VRAM port.
// Ports:
//   clk, rst_L        clock, async active-low reset (also empties the buffer)
//   load              capture ld_addr/ld_data; ignored while full
//   ld_addr, ld_data  incoming CPU write
//   drain             buffered write is being committed this cycle
//   full              buffer holds a write not yet committed
//   addr, data        buffered write contents
module vdp_vram_wr_buf #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst_L,
    input  logic              load,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    input  logic              drain,
    output logic              full,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        data
);

    logic              full_q, full_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;

    always_comb begin
        full_d = full_q;
        addr_d = addr_q;
        data_d = data_q;
        // Load and drain are mutually exclusive: load needs empty, drain needs full.
        if (load && !full_q) begin
            full_d = 1'b1;
            addr_d = ld_addr;
            data_d = ld_data;
        end else if (drain && full_q) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            full_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign full = full_q;
    assign addr = addr_q;
    assign data = data_q;

endmodule

// File: rtl/vdp_vram_read_server.sv
// VRAM read server for the VDP fetch engines. Sequences a 1..4 byte burst
// onto a single-port synchronous VRAM and returns the bytes packed in one
// word with a one-cycle valid pulse. CPU writes go through a one-entry
// buffer that drains only from IDLE, ahead of any new request, so a read
// issued after a write always sees it.
// Ports:
//   clk, rst_L                          clock, async active-low reset
//   req_go, req_addr, req_len, req_ready  burst request handshake
//   rsp_data, rsp_valid                 packed burst bytes (byte k at [8k+7:8k])
//   cpu_wr_en/addr/data, cpu_wr_full    CPU write port
//   ram_addr, ram_we, ram_wdata, ram_rdata  VRAM port (1-cycle read latency)
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | drain the write buffer if full, else accept a request
// S_ISSUE | drive base+issue_cnt each cycle until issue_cnt == len
// S_TAIL  | capture the last byte, schedule rsp_valid
module vdp_vram_read_server
    import vdp_pkg::*;
#(
    parameter int ADDR_W  = VRAM_ADDR_W,
    parameter int MAX_LEN = 4
) (
    input  logic                   clk,
    input  logic                   rst_L,
    input  logic                   req_go,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [1:0]             req_len,
    output logic                   req_ready,
    output logic [8*MAX_LEN-1:0]   rsp_data,
    output logic                   rsp_valid,
    input  logic                   cpu_wr_en,
    input  logic [ADDR_W-1:0]      cpu_wr_addr,
    input  logic [7:0]             cpu_wr_data,
    output logic                   cpu_wr_full,
    output logic [ADDR_W-1:0]      ram_addr,
    output logic                   ram_we,
    output logic [7:0]             ram_wdata,
    input  logic [7:0]             ram_rdata
);

    srv_state_t           state_q, state_d;
    logic [ADDR_W-1:0]    base_addr_q, base_addr_d;
    burst_len_t           len_q, len_d;
    logic [1:0]           issue_cnt_q, issue_cnt_d;
    logic [1:0]           cap_cnt_q, cap_cnt_d;
    // Set the cycle after an address was issued: ram_rdata holds its byte.
    logic                 cap_pend_q, cap_pend_d;
    logic [8*MAX_LEN-1:0] rsp_data_q, rsp_data_d;
    logic                 rsp_valid_q, rsp_valid_d;

    logic                 buf_full;
    logic                 buf_drain;
    logic [ADDR_W-1:0]    buf_addr;
    logic [7:0]           buf_data;

    vdp_vram_wr_buf #(
        .ADDR_W (ADDR_W)
    ) u_wr_buf (
        .clk     (clk),
        .rst_L   (rst_L),
        .load    (cpu_wr_en),
        .ld_addr (cpu_wr_addr),
        .ld_data (cpu_wr_data),
        .drain   (buf_drain),
        .full    (buf_full),
        .addr    (buf_addr),
        .data    (buf_data)
    );

    always_comb begin
        state_d     = state_q;
        base_addr_d = base_addr_q;
        len_d       = len_q;
        issue_cnt_d = issue_cnt_q;
        cap_cnt_d   = cap_cnt_q;
        cap_pend_d  = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = 1'b0;
        buf_drain   = 1'b0;
        ram_addr    = '0;
        ram_we      = 1'b0;
        ram_wdata   = '0;
        req_ready   = 1'b0;

        // Capture runs alongside ISSUE and finishes in TAIL.
        if (cap_pend_q) begin
            rsp_data_d[int'(cap_cnt_q)*8 +: 8] = ram_rdata;
            cap_cnt_d = cap_cnt_q + 2'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (buf_full) begin
                    ram_we    = 1'b1;
                    ram_addr  = buf_addr;
                    ram_wdata = buf_data;
                    buf_drain = 1'b1;
                end else begin
                    req_ready = 1'b1;
                    if (req_go) begin
                        base_addr_d = req_addr;
                        len_d       = req_len;
                        rsp_data_d  = '0;
                        issue_cnt_d = 2'd0;
                        cap_cnt_d   = 2'd0;
                        state_d     = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                // Natural wrap: top address rolls over to 0.
                ram_addr    = base_addr_q + ADDR_W'(issue_cnt_q);
                cap_pend_d  = 1'b1;
                issue_cnt_d = issue_cnt_q + 2'd1;
                if (issue_cnt_q == len_q) begin
                    state_d = S_TAIL;
                end
            end
            S_TAIL: begin
                rsp_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_q     <= S_IDLE;
            base_addr_q <= '0;
            len_q       <= '0;
            issue_cnt_q <= '0;
            cap_cnt_q   <= '0;
            cap_pend_q  <= 1'b0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_addr_q <= base_addr_d;
            len_q       <= len_d;
            issue_cnt_q <= issue_cnt_d;
            cap_cnt_q   <= cap_cnt_d;
            cap_pend_q  <= cap_pend_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign rsp_data    = rsp_data_q;
    assign rsp_valid   = rsp_valid_q;
    assign cpu_wr_full = buf_full;

endmodule

// File: tb/tb_vdp_vram_read_server.sv
// Directed bench for vdp_vram_read_server with a behavioural 16 KB
// synchronous VRAM (1-cycle read latency).
module tb_vdp_vram_read_server;

    logic        clk;
    logic        rst_L;
    logic        req_go;
    logic [13:0] req_addr;
    logic [1:0]  req_len;
    logic        req_ready;
    logic [31:0] rsp_data;
    logic        rsp_valid;
    logic        cpu_wr_en;
    logic [13:0] cpu_wr_addr;
    logic [7:0]  cpu_wr_data;
    logic        cpu_wr_full;
    logic [13:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    logic [7:0]  mem [0:16383];
    int          vectors;
    int          miscompares;
    int          we_seen;

    vdp_vram_read_server dut (
        .clk         (clk),
        .rst_L       (rst_L),
        .req_go      (req_go),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .req_ready   (req_ready),
        .rsp_data    (rsp_data),
        .rsp_valid   (rsp_valid),
        .cpu_wr_en   (cpu_wr_en),
        .cpu_wr_addr (cpu_wr_addr),
        .cpu_wr_data (cpu_wr_data),
        .cpu_wr_full (cpu_wr_full),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    initial we_seen = 0;
    always @(posedge clk) if (ram_we) we_seen <= we_seen + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_L = 1'b0;
        tick();
        tick();
        vectors++;
        if (rsp_data !== 32'h0)    begin miscompares++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
        vectors++;
        if (rsp_valid !== 1'b0)    begin miscompares++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        vectors++;
        if (ram_we !== 1'b0)       begin miscompares++; $display("FAIL reset_ram_we got %b want 0", ram_we); end
        vectors++;
        if (ram_addr !== 14'h0)    begin miscompares++; $display("FAIL reset_ram_addr got %h want 0", ram_addr); end
        vectors++;
        if (ram_wdata !== 8'h0)    begin miscompares++; $display("FAIL reset_ram_wdata got %h want 0", ram_wdata); end
        vectors++;
        if (cpu_wr_full !== 1'b0)  begin miscompares++; $display("FAIL reset_cpu_wr_full got %b want 0", cpu_wr_full); end
        rst_L = 1'b1;
        tick();
        vectors++;
        if (req_ready !== 1'b1)    begin miscompares++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    endtask

    task automatic test_single_byte();
        int we_base;
        we_base = we_seen;
        mem[14'h3F05] = 8'h42;
        req_addr = 14'h3F05;
        req_len  = 2'd0;
        req_go   = 1'b1;
        tick();                                   // cycle 1
        req_go = 1'b0;
        vectors++;
        if (ram_addr !== 14'h3F05) begin miscompares++; $display("FAIL single_addr got %h want 3f05", ram_addr); end
        vectors++;
        if (req_ready !== 1'b0)    begin miscompares++; $display("FAIL single_ready_busy got %b want 0", req_ready); end
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) tick();
            vectors++;
            if (rsp_valid !== (c == 3)) begin
                miscompares++;
                $display("FAIL single_valid cycle %0d got %b want %b", c, rsp_valid, (c == 3));
            end
            if (c == 3) begin
                vectors++;
                if (rsp_data !== 32'h0000_0042) begin miscompares++; $display("FAIL single_data got %h want 00000042", rsp_data); end
                vectors++;
                if (req_ready !== 1'b1) begin miscompares++; $display("FAIL single_ready_back got %b want 1", req_ready); end
            end
        end
        vectors++;
        if (we_seen != we_base) begin miscompares++; $display("FAIL single_no_write got %0d writes want 0", we_seen - we_base); end
    endtask

    task automatic test_full_burst();
        logic [13:0] exp_addr [4];
        exp_addr[0] = 14'h1000; exp_addr[1] = 14'h1001;
        exp_addr[2] = 14'h1002; exp_addr[3] = 14'h1003;
        mem[14'h1000] = 8'h11; mem[14'h1001] = 8'h22;
        mem[14'h1002] = 8'h33; mem[14'h1003] = 8'h44;
        req_addr = 14'h1000;
        req_len  = 2'd3;
        req_go   = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            req_go = 1'b0;
            if (c <= 4) begin
                vectors++;
                if (ram_addr !== exp_addr[c-1]) begin
                    miscompares++;
                    $display("FAIL full_addr cycle %0d got %h want %h", c, ram_addr, exp_addr[c-1]);
                end
            end
            vectors++;
            if (rsp_valid !== (c == 6)) begin
                miscompares++;
                $display("FAIL full_valid cycle %0d got %b want %b", c, rsp_valid, (c == 6));
            end
            if (c == 6) begin
                vectors++;
                if (rsp_data !== 32'h4433_2211) begin miscompares++; $display("FAIL full_data got %h want 44332211", rsp_data); end
            end
        end
    endtask

    task automatic test_wrap();
        mem[14'h3FFF] = 8'hAA;
        mem[14'h0000] = 8'hBB;
        req_addr = 14'h3FFF;
        req_len  = 2'd1;
        req_go   = 1'b1;
        tick();                                   // cycle 1
        req_go = 1'b0;
        tick();                                   // cycle 2
        vectors++;
        if (ram_addr !== 14'h0000) begin miscompares++; $display("FAIL wrap_addr got %h want 0000", ram_addr); end
        tick();
        tick();                                   // cycle 4
        vectors++;
        if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL wrap_valid got %b want 1", rsp_valid); end
        vectors++;
        if (rsp_data !== 32'h0000_BBAA) begin miscompares++; $display("FAIL wrap_data got %h want 0000bbaa", rsp_data); end
        tick();
    endtask

    task automatic test_coherence();
        mem[14'h3F80] = 8'h00;
        req_addr = 14'h1000;
        req_len  = 2'd3;
        req_go   = 1'b1;
        tick();                                   // cycle 1
        req_go      = 1'b0;
        cpu_wr_en   = 1'b1;
        cpu_wr_addr = 14'h3F80;
        cpu_wr_data = 8'h7C;
        tick();                                   // cycle 2
        cpu_wr_en = 1'b0;
        vectors++;
        if (cpu_wr_full !== 1'b1) begin miscompares++; $display("FAIL coh_full got %b want 1", cpu_wr_full); end
        for (int c = 3; c <= 5; c++) begin
            tick();
            vectors++;
            if (ram_we !== 1'b0) begin miscompares++; $display("FAIL coh_no_we_in_burst cycle %0d got %b want 0", c, ram_we); end
        end
        tick();                                   // cycle 6: burst ends
        vectors++;
        if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL coh_burst_valid got %b want 1", rsp_valid); end
        vectors++;
        if (ram_we !== 1'b1) begin miscompares++; $display("FAIL coh_drain_we got %b want 1", ram_we); end
        vectors++;
        if (ram_addr !== 14'h3F80) begin miscompares++; $display("FAIL coh_drain_addr got %h want 3f80", ram_addr); end
        vectors++;
        if (ram_wdata !== 8'h7C) begin miscompares++; $display("FAIL coh_drain_data got %h want 7c", ram_wdata); end
        vectors++;
        if (req_ready !== 1'b0) begin miscompares++; $display("FAIL coh_ready_drain got %b want 0", req_ready); end
        req_addr = 14'h3F80;
        req_len  = 2'd0;
        req_go   = 1'b1;
        tick();                                   // cycle 7
        vectors++;
        if (cpu_wr_full !== 1'b0) begin miscompares++; $display("FAIL coh_full_clear got %b want 0", cpu_wr_full); end
        vectors++;
        if (req_ready !== 1'b1) begin miscompares++; $display("FAIL coh_ready_after got %b want 1", req_ready); end
        vectors++;
        if (mem[14'h3F80] !== 8'h7C) begin miscompares++; $display("FAIL coh_mem got %h want 7c", mem[14'h3F80]); end
        vectors++;
        if (rsp_data !== 32'h4433_2211) begin miscompares++; $display("FAIL coh_hold_data got %h want 44332211", rsp_data); end
        tick();                                   // cycle 8
        req_go = 1'b0;
        vectors++;
        if (ram_addr !== 14'h3F80) begin miscompares++; $display("FAIL coh_read_addr got %h want 3f80", ram_addr); end
        tick();
        tick();                                   // cycle 10
        vectors++;
        if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL coh_read_valid got %b want 1", rsp_valid); end
        vectors++;
        if (rsp_data !== 32'h0000_007C) begin miscompares++; $display("FAIL coh_read_data got %h want 0000007c", rsp_data); end
        tick();
    endtask

    task automatic test_back_to_back();
        req_addr = 14'h1000;
        req_len  = 2'd1;
        req_go   = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 1) begin
                req_addr = 14'h3F05;
                req_len  = 2'd0;
            end
            if (c == 5) req_go = 1'b0;
            vectors++;
            if (rsp_valid !== (c == 4 || c == 7)) begin
                miscompares++;
                $display("FAIL b2b_valid cycle %0d got %b want %b", c, rsp_valid, (c == 4 || c == 7));
            end
            if (c == 4) begin
                vectors++;
                if (rsp_data !== 32'h0000_2211) begin miscompares++; $display("FAIL b2b_data1 got %h want 00002211", rsp_data); end
                vectors++;
                if (req_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready got %b want 1", req_ready); end
            end
            if (c == 5) begin
                vectors++;
                if (ram_addr !== 14'h3F05) begin miscompares++; $display("FAIL b2b_addr2 got %h want 3f05", ram_addr); end
            end
            if (c == 7) begin
                vectors++;
                if (rsp_data !== 32'h0000_0042) begin miscompares++; $display("FAIL b2b_data2 got %h want 00000042", rsp_data); end
            end
        end
    endtask

    task automatic test_mid_burst_reset();
        mem[14'h2000] = 8'h00;
        req_addr = 14'h1000;
        req_len  = 2'd3;
        req_go   = 1'b1;
        tick();                                   // cycle 1
        req_go      = 1'b0;
        cpu_wr_en   = 1'b1;
        cpu_wr_addr = 14'h2000;
        cpu_wr_data = 8'h99;
        tick();                                   // cycle 2
        cpu_wr_en = 1'b0;
        rst_L     = 1'b0;
        #1;
        vectors++;
        if (rsp_data !== 32'h0)   begin miscompares++; $display("FAIL mrst_rsp_data got %h want 0", rsp_data); end
        vectors++;
        if (rsp_valid !== 1'b0)   begin miscompares++; $display("FAIL mrst_rsp_valid got %b want 0", rsp_valid); end
        vectors++;
        if (ram_addr !== 14'h0)   begin miscompares++; $display("FAIL mrst_ram_addr got %h want 0", ram_addr); end
        vectors++;
        if (ram_we !== 1'b0)      begin miscompares++; $display("FAIL mrst_ram_we got %b want 0", ram_we); end
        vectors++;
        if (ram_wdata !== 8'h0)   begin miscompares++; $display("FAIL mrst_ram_wdata got %h want 0", ram_wdata); end
        vectors++;
        if (cpu_wr_full !== 1'b0) begin miscompares++; $display("FAIL mrst_cpu_wr_full got %b want 0", cpu_wr_full); end
        tick();
        tick();
        rst_L = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            vectors++;
            if (rsp_valid !== 1'b0 || ram_we !== 1'b0 || req_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL mrst_after cycle %0d got valid=%b we=%b ready=%b want 0 0 1",
                         c, rsp_valid, ram_we, req_ready);
            end
        end
        vectors++;
        if (mem[14'h2000] !== 8'h00) begin miscompares++; $display("FAIL mrst_write_discarded got %h want 00", mem[14'h2000]); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        rst_L       = 1'b0;
        req_go      = 1'b0;
        req_addr    = '0;
        req_len     = '0;
        cpu_wr_en   = 1'b0;
        cpu_wr_addr = '0;
        cpu_wr_data = '0;
        #2;
        test_reset();
        test_single_byte();
        tick();
        test_full_burst();
        test_wrap();
        test_coherence();
        test_back_to_back();
        tick();
        test_mid_burst_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
